// File: rtl/uart_host_pkg.sv
// Shared definitions for the UART host initiator: command bytes, FSM states,
// packet lengths and the outgoing packet byte selector.
package uart_host_pkg;

  localparam logic [7:0] CMD_WRITE      = 8'h01;
  localparam logic [7:0] CMD_READ       = 8'h00;
  localparam logic [3:0] LAST_IDX_READ  = 4'd4;
  localparam logic [3:0] LAST_IDX_WRITE = 4'd8;
  localparam logic [1:0] RSP_LAST_BYTE  = 2'd3;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, DONE} state_e;

  // Byte idx of a packet: 0 = command, 1..4 = address, 5..8 = write data.
  function automatic logic [7:0] pkt_byte(input logic [3:0] idx, input logic wr,
                                          input logic [31:0] addr, input logic [31:0] data);
    logic [7:0] b;
    case (idx)
      4'd0:    b = wr ? CMD_WRITE : CMD_READ;
      4'd1:    b = addr[7:0];
      4'd2:    b = addr[15:8];
      4'd3:    b = addr[23:16];
      4'd4:    b = addr[31:24];
      4'd5:    b = data[7:0];
      4'd6:    b = data[15:8];
      4'd7:    b = data[23:16];
      4'd8:    b = data[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_host_phy.sv
// 8N1 serializer/deserializer, LSB first, cfg_div clocks per bit. The transmitter
// accepts a new byte on the cycle its stop bit completes, so packets have no gaps.
module uart_host_phy (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cfg_div,
  input  logic        tx_start,
  input  logic [7:0]  tx_byte,
  output logic        tx_done,
  output logic        txd,
  input  logic        rx_en,
  input  logic        rxd,
  output logic [7:0]  rx_byte,
  output logic        rx_valid
);

  logic        txd_q, tx_busy_q, tx_last;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;
  logic [8:0]  tx_sh_q;

  assign tx_last = tx_busy_q && (tx_cnt_q == cfg_div - 16'd1);
  assign tx_done = tx_last && (tx_bit_q == 4'd9);
  assign txd     = txd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd_q     <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_cnt_q  <= 16'd0;
      tx_bit_q  <= 4'd0;
      tx_sh_q   <= 9'd0;
    end else if (tx_start) begin
      txd_q     <= 1'b0;
      tx_busy_q <= 1'b1;
      tx_cnt_q  <= 16'd0;
      tx_bit_q  <= 4'd0;
      tx_sh_q   <= {1'b1, tx_byte};
    end else if (tx_done) begin
      txd_q     <= 1'b1;
      tx_busy_q <= 1'b0;
    end else if (tx_last) begin
      // Shifting in ones makes the stop bit fall out after the eight data bits.
      txd_q    <= tx_sh_q[0];
      tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
      tx_cnt_q <= 16'd0;
      tx_bit_q <= tx_bit_q + 4'd1;
    end else if (tx_busy_q) begin
      tx_cnt_q <= tx_cnt_q + 16'd1;
    end
  end

  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_busy_q, rx_valid_q, rx_sample;
  logic [15:0] rx_cnt_q;
  logic [3:0]  rx_bit_q;
  logic [7:0]  rx_sh_q, rx_byte_q;

  // Start bit is checked half a bit after the edge; later bits one full bit apart.
  assign rx_sample = (rx_bit_q == 4'd0) ? (rx_cnt_q == (cfg_div >> 1) - 16'd1)
                                        : (rx_cnt_q == cfg_div - 16'd1);
  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 4'd0;
      rx_sh_q    <= 8'd0;
      rx_byte_q  <= 8'd0;
    end else begin
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_valid_q <= 1'b0;
      if (!rx_en) begin
        rx_busy_q <= 1'b0;
      end else if (!rx_busy_q) begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_busy_q <= 1'b1;
          rx_cnt_q  <= 16'd0;
          rx_bit_q  <= 4'd0;
        end
      end else if (rx_sample) begin
        rx_cnt_q <= 16'd0;
        if (rx_bit_q == 4'd0) begin
          if (rx_s2_q) rx_busy_q <= 1'b0;
          else         rx_bit_q  <= 4'd1;
        end else if (rx_bit_q == 4'd9) begin
          rx_busy_q <= 1'b0;
          if (rx_s2_q) begin
            rx_valid_q <= 1'b1;
            rx_byte_q  <= rx_sh_q;
          end
        end else begin
          rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 4'd1;
        end
      end else begin
        rx_cnt_q <= rx_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/uart_host_initiator.sv
// Bus-to-UART host bridge: serializes read/write packets and collects 4-byte read replies.
// Optional read timeout is enabled by defining UART_HOST_INIT_TIMEOUT_EN.
module uart_host_initiator
  import uart_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cfg_div,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_writedata,
  output logic        rsp_valid,
  output logic [31:0] rsp_readdata,
  output logic        rsp_err,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  state_e      state_q, state_d;
  logic        write_q, tx_start, tx_done, rx_valid, rx_done, timeout;
  logic [31:0] addr_q, wdata_q, acc_q, rdata_q;
  logic [3:0]  idx_q, last_idx;
  logic [1:0]  rx_cnt_q;
  logic [7:0]  tx_byte, rx_byte;

  uart_host_phy u_phy (
    .clk      (clk),
    .rst      (rst),
    .cfg_div  (cfg_div),
    .tx_start (tx_start),
    .tx_byte  (tx_byte),
    .tx_done  (tx_done),
    .txd      (uart_txd),
    .rx_en    (state_q == WAIT_RX),
    .rxd      (uart_rxd),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid)
  );

  assign last_idx     = write_q ? LAST_IDX_WRITE : LAST_IDX_READ;
  assign rx_done      = rx_valid && (rx_cnt_q == RSP_LAST_BYTE);
  assign rsp_readdata = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = SEND;
      SEND:    if (tx_done && idx_q == last_idx) state_d = write_q ? DONE : WAIT_RX;
      WAIT_RX: if (rx_done || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The command byte launches in the acceptance cycle so the start bit follows immediately.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    tx_start  = 1'b0;
    tx_byte   = 8'h00;
    case (state_q)
      IDLE: begin
        req_ready = !rst;
        tx_start  = req_valid && !rst;
        tx_byte   = pkt_byte(4'd0, req_write, req_address, req_writedata);
      end
      SEND: begin
        tx_start = tx_done && (idx_q != last_idx);
        tx_byte  = pkt_byte(idx_q + 4'd1, write_q, addr_q, wdata_q);
      end
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q  <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      idx_q    <= 4'd0;
      rx_cnt_q <= 2'd0;
      acc_q    <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          write_q  <= req_write;
          addr_q   <= req_address;
          wdata_q  <= req_writedata;
          idx_q    <= 4'd0;
          rx_cnt_q <= 2'd0;
          acc_q    <= 32'd0;
        end
        SEND: begin
          if (tx_done) idx_q <= idx_q + 4'd1;
          if (state_d == DONE) rdata_q <= 32'd0;
        end
        WAIT_RX: begin
          if (rx_valid) begin
            acc_q    <= {rx_byte, acc_q[31:8]};
            rx_cnt_q <= rx_cnt_q + 2'd1;
          end
          if (state_d == DONE) rdata_q <= rx_done ? {rx_byte, acc_q[31:8]} : 32'd0;
        end
        default: ;
      endcase
    end
  end

`ifdef UART_HOST_INIT_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  logic        err_q;

  assign timeout = (state_q == WAIT_RX) && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
  assign rsp_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == WAIT_RX) ? to_cnt_q + 32'd1 : 32'd0;
      if (state_q != DONE && state_d == DONE) err_q <= timeout && !rx_done;
    end
  end
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/uart_host_initiator.md
UART_HOST_INITIATOR -- requirements
Module: uart_host_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, the read-response timeout in clk cycles.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port cfg_div, input, 16, clk cycles per UART bit; legal range >= 4.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, request accepted when valid and ready are both high.
REQ-007 SHALL have port req_write, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have ports req_address (input, 32) and req_writedata (input, 32).
REQ-009 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-010 SHALL have ports rsp_readdata (output, 32) and rsp_err (output, 1, timeout flag).
REQ-011 SHALL have port uart_txd, output, 1, serial command line to the UART host.
REQ-012 SHALL have port uart_rxd, input, 1, serial response line from the UART host.

Function
REQ-013 SHALL use 8N1 framing with idle-high lines, LSB first, and each bit held exactly cfg_div cycles.
REQ-014 SHALL send each packet as a command byte, then address bytes 0..3, then (writes only) data bytes 0..3; all bytes least-significant first.
REQ-015 SHALL use command byte 8'h01 for a write and 8'h00 for a read.
REQ-016 SHALL implement main FSM states IDLE, SEND, WAIT_RX and DONE.
REQ-017 SHALL assert req_ready only in IDLE, and SHALL capture address, data and write flag on acceptance.
REQ-018 SHALL move from IDLE to SEND on acceptance, with the start bit beginning on the next cycle.
REQ-019 SHALL, in SEND, use a 4-bit byte index and advance it when each stop bit completes; after the last byte (index 4 for a read, 8 for a write) it SHALL go to WAIT_RX for a read or DONE for a write.
REQ-020 SHALL, in WAIT_RX, assemble 4 received bytes LSB first and go to DONE when the 4th stop bit is sampled.
REQ-021 SHALL, in DONE, pulse rsp_valid for exactly one cycle and return to IDLE; rsp_readdata SHALL be 0 for writes.
REQ-022 SHALL pass uart_rxd through a 2-flop synchronizer.
REQ-023 SHALL detect a start bit on a falling edge seen only in WAIT_RX, and SHALL sample it at cfg_div/2 (integer divide); a start bit that is high at that sample point SHALL be discarded.
REQ-024 SHALL sample data and stop bits every cfg_div cycles after the start-bit sample point.
REQ-025 SHALL discard a byte whose stop bit samples low; the byte count SHALL NOT advance.
REQ-026 SHALL ignore bytes on uart_rxd received outside WAIT_RX.
REQ-027 SHALL keep rsp_readdata stable until the next rsp_valid.

Reset
REQ-028 SHALL, on reset, set: FSM to IDLE, uart_txd 1, req_ready 0 during reset and 1 on the first cycle after, rsp_valid 0, rsp_readdata 0, rsp_err 0, all counters 0.
REQ-029 SHALL abandon any packet in progress when reset is asserted mid-packet, with no rsp_valid; uart_txd SHALL return high immediately.

Configuration
REQ-030 SHALL, when UART_HOST_INIT_TIMEOUT_EN is defined, count cycles in WAIT_RX; at TIMEOUT_CYCLES it SHALL go to DONE with rsp_err 1 and rsp_readdata 0.
REQ-031 SHALL, when UART_HOST_INIT_TIMEOUT_EN is undefined, tie rsp_err to 0 and wait in WAIT_RX indefinitely.

Structure
REQ-032 SHALL take the command-byte constants, the FSM state enum and the packet lengths from package uart_host_pkg.
REQ-033 SHALL place the bit serializer and deserializer in one sub-module, uart_host_phy (tx_start/tx_byte/tx_done, rx_byte/rx_valid).

Verification
REQ-034 Write with addr 32'h1000_0004 and data 32'hDEAD_BEEF, cfg_div 10 -> 9 bytes 01 04 00 00 10 EF BE AD DE on uart_txd, 900 cycles; rsp_valid one cycle; rsp_err 0.
REQ-035 Read with addr 32'h0000_0010, model returns bytes 78 56 34 12 -> TX bytes 00 10 00 00 00; rsp_readdata 32'h1234_5678.
REQ-036 req_valid held high across back-to-back requests -> req_ready low from acceptance until the cycle after rsp_valid; second packet starts only then.
REQ-037 Read with no reply, macro defined, TIMEOUT_CYCLES 500 -> rsp_valid with rsp_err 1 at 500 cycles after WAIT_RX entry; macro undefined -> no rsp_valid.
REQ-038 rst pulsed at byte 3 of a write -> uart_txd high at once, no rsp_valid, req_ready 1 on the cycle after release.
REQ-039 Response byte with a low stop bit, then 4 valid bytes -> the corrupted byte is dropped and rsp_readdata is taken from the valid bytes.
